// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO read port and sends each one as an
// asynchronous serial frame (start bit, n data bits LSB-first, stop bit).
// All outputs are registered from the current state, so the line and strobe
// trail the state register by one clk cycle.
module fifo_uart_tx #(
  parameter int unsigned n   = 8,
  parameter int unsigned div = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] fifo_data,
  input  logic         fifo_empty,
  output logic         fifo_clk_o,
  output logic         tx,
  output logic         busy
);

  localparam int unsigned BAUD_W = (div > 1) ? $clog2(div) : 1;
  localparam int unsigned BIT_W  = $clog2(n + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(div - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(n - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    SETTLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [n-1:0]      shreg_q, shreg_d;
  logic              tx_d, busy_d, strobe_d;
  logic              baud_wrap;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters, shift register and output decode
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    strobe_d  = 1'b0;
    baud_wrap = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!fifo_empty) begin
          state_d = POP;
        end
      end

      POP: begin
        strobe_d = 1'b1;
        state_d  = SETTLE;
      end

      // FIFO output has had a full cycle to settle after the strobe edge
      SETTLE: begin
        shreg_d = fifo_data;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end

      START: begin
        tx_d = 1'b0;
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        tx_d = shreg_q[0];
        if (baud_wrap) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      // Last stop cycle decides between back-to-back pop and idle
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = fifo_empty ? IDLE : POP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_clk_o <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx         <= tx_d;
      busy       <= busy_d;
      fifo_clk_o <= strobe_d;
    end
  end

endmodule
